timer_intr_gen: RTL and testbench

//  Memory-mapped interrupt source for the pipelined RISC-V core: produces the t_intr and e_intr

---
 rtl/timer_intr_gen.sv | 128 ++++++++++++
 tb/tb_timer_intr_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/timer_intr_gen.sv
// Memory-mapped interrupt source: prescaled 32-bit compare timer plus a synchronised
// external-button edge detector, exposed as t_intr_o / e_intr_o levels.
module timer_intr_gen #(
  parameter int DW         = 32,
  parameter int ADDRW      = 12,
  parameter int PRESCALE_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_i,
  input  logic             we_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o,
  input  logic             e_btn_i,
  output logic             t_intr_o,
  output logic             e_intr_o
);

  localparam logic [PRESCALE_W-1:0] PSC_ONE = 1;
  localparam logic [DW-1:0]         CNT_ONE = 1;

  // Bus handshake: a transfer happens at the rising edge where sel_i is high;
  // we_i chooses write (1) or read (0). There is no stall, reads return next cycle.
  logic [2:0]            w_off;
  logic                  w_wr, w_rd;
  logic                  w_wr_ctrl, w_wr_psc, w_wr_count, w_wr_cmp, w_wr_status;
  logic                  w_tick, w_cnt_eq, w_match, w_e_rise;
  logic                  w_unused;

  logic                  r_en, r_auto, r_tie, r_eie;
  logic [PRESCALE_W-1:0] r_prescale, r_psc;
  logic [DW-1:0]         r_count, r_compare, r_rdata;
  logic                  r_tpend, r_epend;
  logic                  r_sync1, r_sync2, r_sync_prev;

  assign w_off       = addr_i[4:2];
  assign w_wr        = sel_i & we_i;
  assign w_rd        = sel_i & ~we_i;
  assign w_wr_ctrl   = w_wr & (w_off == 3'd0);
  assign w_wr_psc    = w_wr & (w_off == 3'd1);
  assign w_wr_count  = w_wr & (w_off == 3'd2);
  assign w_wr_cmp    = w_wr & (w_off == 3'd3);
  assign w_wr_status = w_wr & (w_off == 3'd4);
  assign w_unused    = &{1'b0, addr_i[ADDRW-1:5], addr_i[1:0]};

  assign w_tick   = r_en & (r_psc == r_prescale);
  assign w_cnt_eq = (r_count == r_compare);
  // A software COUNT write on a tick edge suppresses the match for that edge.
  assign w_match  = w_tick & w_cnt_eq & ~w_wr_count;
  assign w_e_rise = r_sync2 & ~r_sync_prev;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_en <= 1'b0; r_auto <= 1'b0; r_tie <= 1'b0; r_eie <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en <= wdata_i[0]; r_auto <= wdata_i[1]; r_tie <= wdata_i[2]; r_eie <= wdata_i[3];
    end else if (w_match && !r_auto) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_prescale <= '0;
      r_compare  <= '0;
    end else begin
      if (w_wr_psc) r_prescale <= wdata_i[PRESCALE_W-1:0];
      if (w_wr_cmp) r_compare  <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                               r_psc <= '0;
    else if (w_wr_ctrl || w_wr_psc || w_wr_count) r_psc <= '0;
    else if (w_tick)                          r_psc <= '0;
    else if (r_en)                            r_psc <= r_psc + PSC_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          r_count <= '0;
    else if (w_wr_count) r_count <= wdata_i;
    else if (w_tick) begin
      if (!w_cnt_eq)     r_count <= r_count + CNT_ONE;
      else if (r_auto)   r_count <= '0;
    end
  end

  // Pending bits: a set on the same edge as a write-1-to-clear takes priority.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tpend <= 1'b0;
      r_epend <= 1'b0;
    end else begin
      if (w_match)                           r_tpend <= 1'b1;
      else if (w_wr_status && wdata_i[0])    r_tpend <= 1'b0;
      if (w_e_rise)                          r_epend <= 1'b1;
      else if (w_wr_status && wdata_i[1])    r_epend <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= 1'b0; r_sync2 <= 1'b0; r_sync_prev <= 1'b0;
    end else begin
      r_sync1 <= e_btn_i; r_sync2 <= r_sync1; r_sync_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_rdata <= '0;
    else if (w_rd) begin
      case (w_off)
        3'd0:    r_rdata <= {{(DW-4){1'b0}}, r_eie, r_tie, r_auto, r_en};
        3'd1:    r_rdata <= {{(DW-PRESCALE_W){1'b0}}, r_prescale};
        3'd2:    r_rdata <= r_count;
        3'd3:    r_rdata <= r_compare;
        3'd4:    r_rdata <= {{(DW-2){1'b0}}, r_epend, r_tpend};
        default: r_rdata <= '0;
      endcase
    end
  end

  assign rdata_o  = r_rdata;
  assign t_intr_o = r_tpend & r_tie;
  assign e_intr_o = r_epend & r_eie;

endmodule

// File: tb/tb_timer_intr_gen.sv
// Directed bench for timer_intr_gen: bus driver tasks, immediate-assertion checks,
// expected-value queue for reads, and a single summary line.
module tb_timer_intr_gen;

  localparam logic [11:0] A_CTRL = 12'h000, A_PSC = 12'h004, A_COUNT = 12'h008,
                          A_CMP  = 12'h00C, A_STAT = 12'h010, A_RSV = 12'h014;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        sel_i = 1'b0;
  logic        we_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        e_btn_i = 1'b0;
  logic        t_intr_o, e_intr_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  timer_intr_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .e_btn_i(e_btn_i),
    .t_intr_o(t_intr_o), .e_intr_o(e_intr_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drivers: called at a negedge, the transfer happens at the following posedge,
  // and they return at the negedge after it.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd_check(input logic [11:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    sel_i = 1'b0;
    check(tag, rdata_o, exp_q.pop_front());
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_t_intr", {31'b0, t_intr_o}, 32'd0);
    check("rst_e_intr", {31'b0, e_intr_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    wait_neg(2);
    rst_i = 1'b1;
    wait_neg(1);
    rd_check(A_COUNT, 32'd0, "rst_count");

    // Register read-back and reserved bits
    bus_write(A_CTRL, 32'hFFFF_FFF0);
    rd_check(A_CTRL, 32'd0, "ctrl_upper_bits");
    bus_write(A_RSV, 32'hFFFF_FFFF);
    rd_check(A_RSV, 32'd0, "reserved_off5");
    bus_write(A_PSC, 32'hABCD_0003);
    rd_check(A_PSC, 32'h0000_0003, "psc_width");

    // Periodic auto-reload: PRESCALE=3, COMPARE=5 -> match every 24 edges
    bus_write(A_CMP, 32'd5);
    rd_check(A_CMP, 32'd5, "compare_rb");
    bus_write(A_CTRL, 32'h7);
    wait_neg(23);
    check("auto_edge23", {31'b0, t_intr_o}, 32'd0);
    wait_neg(1);
    check("auto_edge24", {31'b0, t_intr_o}, 32'd1);
    bus_write(A_STAT, 32'h1);
    check("w1c_edge25", {31'b0, t_intr_o}, 32'd0);
    wait_neg(22);
    check("auto_edge47", {31'b0, t_intr_o}, 32'd0);
    wait_neg(1);
    check("auto_edge48", {31'b0, t_intr_o}, 32'd1);

    // W1C coincident with a match: set wins; following W1C clears
    bus_write(A_STAT, 32'h1);
    check("w1c_edge49", {31'b0, t_intr_o}, 32'd0);
    wait_neg(22);
    check("auto_edge71", {31'b0, t_intr_o}, 32'd0);
    bus_write(A_STAT, 32'h1);
    check("set_beats_w1c", {31'b0, t_intr_o}, 32'd1);
    bus_write(A_STAT, 32'h1);
    check("w1c_after_set", {31'b0, t_intr_o}, 32'd0);

    // Asynchronous reset in the middle of counting
    wait_neg(23);
    check("auto_edge96", {31'b0, t_intr_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_t_intr", {31'b0, t_intr_o}, 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    check("midrst_e_intr", {31'b0, e_intr_o}, 32'd0);
    wait_neg(1);
    rst_i = 1'b1;
    wait_neg(1);
    rd_check(A_COUNT, 32'd0, "midrst_count");
    rd_check(A_CTRL, 32'd0, "midrst_ctrl");

    // One-shot: PRESCALE=0, COMPARE=2, CTRL=EN|T_IE
    bus_write(A_PSC, 32'd0);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'h5);
    wait_neg(2);
    check("oneshot_edge2", {31'b0, t_intr_o}, 32'd0);
    wait_neg(1);
    check("oneshot_edge3", {31'b0, t_intr_o}, 32'd1);
    rd_check(A_CTRL, 32'h4, "oneshot_ctrl");
    wait_neg(5);
    rd_check(A_COUNT, 32'd2, "oneshot_count_hold");
    rd_check(A_STAT, 32'h1, "oneshot_status");

    // Wrap: COUNT=0xFFFFFFFF, COMPARE=7 -> wraps to 0 silently, match at 7
    bus_write(A_STAT, 32'h1);
    bus_write(A_COUNT, 32'hFFFF_FFFF);
    bus_write(A_CMP, 32'd7);
    bus_write(A_CTRL, 32'h5);
    wait_neg(1);
    rd_check(A_COUNT, 32'd0, "wrap_count0");
    check("wrap_no_pend", {31'b0, t_intr_o}, 32'd0);
    wait_neg(6);
    check("wrap_edge8", {31'b0, t_intr_o}, 32'd0);
    wait_neg(1);
    check("wrap_edge9", {31'b0, t_intr_o}, 32'd1);
    rd_check(A_COUNT, 32'd7, "wrap_count7");

    // External button with E_IE; T_IE cleared masks t_intr_o but keeps T_PEND
    bus_write(A_CTRL, 32'h8);
    check("tie_mask", {31'b0, t_intr_o}, 32'd0);
    e_btn_i = 1'b1;
    wait_neg(2);
    check("ebtn_edge2", {31'b0, e_intr_o}, 32'd0);
    wait_neg(1);
    check("ebtn_edge3", {31'b0, e_intr_o}, 32'd1);
    rd_check(A_STAT, 32'h3, "status_both");
    wait_neg(10);
    bus_write(A_STAT, 32'h2);
    check("ebtn_w1c", {31'b0, e_intr_o}, 32'd0);
    wait_neg(33);
    check("ebtn_held_once", {31'b0, e_intr_o}, 32'd0);
    rd_check(A_STAT, 32'h1, "status_tpend_kept");
    e_btn_i = 1'b0;
    wait_neg(4);
    check("ebtn_release", {31'b0, e_intr_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
